// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline-control types and constants: scoreboard entry layout, pipeline-state
// encodings, the PC register index and the NOP exec-control vector. Pure declarations, no timing.
package pipeline_hazard_ctrl_pkg;

    localparam logic [3:0] PC_REGISTER = 4'd15;

    localparam int SB_ENTRY_W = 5;

    typedef struct packed {
        logic                  vld;
        logic [SB_ENTRY_W-2:0] rgn;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{vld: 1'b0, rgn: '0};

    typedef enum logic {
        PS_RUN   = 1'b0,
        PS_FLUSH = 1'b1
    } pipe_state_e;

    // Loaded into exec_ctrl by the top level whenever bubble_e is high.
    localparam int                     EXEC_CTRL_W   = 16;
    localparam logic [EXEC_CTRL_W-1:0] EXEC_NOP_CTRL = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sb_match.sv
// Compares one decode source register against one scoreboard entry; purely combinational.
// R15 never matches because the PC value is supplied by the PC logic, not the regfile.
module pipeline_hazard_ctrl_sb_match
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [3:0] src,
    input  logic       src_used,
    input  sb_entry_t  entry,
    output logic       hit
);

    assign hit = src_used & (src != PC_REGISTER) & entry.vld & (entry.rgn == src);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Fetch/decode stall, exec bubble and post-redirect flush control for the 5-stage pipeline.
// Outputs are combinational from registered scoreboard/FSM plus current decode inputs.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int WB_BYPASS    = 0,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             decd_valid,
    input  logic [3:0]       decd_rn,
    input  logic             decd_rn_used,
    input  logic [3:0]       decd_rm,
    input  logic             decd_rm_used,
    input  logic [3:0]       decd_rd,
    input  logic             decd_rd_write,
    input  logic             exec_redirect,
    output logic             stall_fd,
    output logic             bubble_e,
    output logic             flush,
    output logic             issue,
    output logic             busy_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    // With a forwarding regfile the wrbk entry is already readable, so it drops out of the compare.
    localparam logic [2:0] CMP_MASK     = (WB_BYPASS != 0) ? 3'b011 : 3'b111;

    sb_entry_t        sb_e_q, sb_e_d;
    sb_entry_t        sb_m_q, sb_m_d;
    sb_entry_t        sb_w_q, sb_w_d;
    pipe_state_e      state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    sb_entry_t  sb_ent [3];
    logic [2:0] hit_rn;
    logic [2:0] hit_rm;
    logic       dv_eff;
    logic       redir_eff;
    logic       run;
    logic       hazard;

    assign sb_ent[0] = sb_e_q;
    assign sb_ent[1] = sb_m_q;
    assign sb_ent[2] = sb_w_q;

    for (genvar i = 0; i < 3; i++) begin : g_match
        pipeline_hazard_ctrl_sb_match u_rn (
            .src      (decd_rn),
            .src_used (decd_rn_used),
            .entry    (sb_ent[i]),
            .hit      (hit_rn[i])
        );
        pipeline_hazard_ctrl_sb_match u_rm (
            .src      (decd_rm),
            .src_used (decd_rm_used),
            .entry    (sb_ent[i]),
            .hit      (hit_rm[i])
        );
    end

    // While reset is held the outputs behave as if decode were empty and no redirect occurred.
    always_comb begin
        dv_eff    = decd_valid & ~reset;
        redir_eff = exec_redirect & ~reset;
        run       = (state_q == PS_RUN);
        hazard    = dv_eff & run & (|((hit_rn | hit_rm) & CMP_MASK));
        issue     = dv_eff & ~hazard & run & ~redir_eff;
        stall_fd  = hazard & ~redir_eff;
        bubble_e  = ~issue;
        flush     = ~reset & (redir_eff | ~run);
    end

    always_comb begin
        sb_e_d = SB_EMPTY;
        if (issue) begin
            sb_e_d = '{vld: decd_rd_write, rgn: decd_rd};
        end
        sb_m_d = sb_e_q;
        sb_w_d = sb_m_q;
    end

    // fcnt counts the FLUSH-state cycles still to come, including the current one.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            PS_RUN: begin
                if (redir_eff && (FLUSH_RELOAD != 3'd0)) begin
                    state_d = PS_FLUSH;
                    fcnt_d  = FLUSH_RELOAD;
                end
            end
            PS_FLUSH: begin
                if (redir_eff) begin
                    fcnt_d = FLUSH_RELOAD;
                end else if (fcnt_q <= 3'd1) begin
                    state_d = PS_RUN;
                    fcnt_d  = 3'd0;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = PS_RUN;
                fcnt_d  = 3'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_fd && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_e_q      <= SB_EMPTY;
            sb_m_q      <= SB_EMPTY;
            sb_w_q      <= SB_EMPTY;
            state_q     <= PS_RUN;
            fcnt_q      <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_e_q      <= sb_e_d;
            sb_m_q      <= sb_m_d;
            sb_w_q      <= sb_w_d;
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign busy_state = (state_q == PS_FLUSH);
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule
